// File: rtl/wb_pkg.sv
// wb_pkg: shared widths and the late-FPU buffer entry type for the writeback stage
package wb_pkg;
  localparam int XLEN      = 32;
  localparam int REG_AW    = 5;
  localparam int BUF_DEPTH = 2;
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } fpu_wb_entry_t;
endpackage

// File: rtl/wb_fpu_buf.sv
// wb_fpu_buf: in-order buffer for late FPU results with WAW kill and pending-destination mask
module wb_fpu_buf
  import wb_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enq_i,
  input  logic [REG_AW-1:0]    enq_rd_i,
  input  logic [XLEN-1:0]      enq_data_i,
  input  logic                 pfw_i,
  input  logic [REG_AW-1:0]    pfw_rd_i,
  output logic                 full_o,
  output logic                 drain_o,
  output logic [REG_AW-1:0]    head_rd_o,
  output logic [XLEN-1:0]      head_data_o,
  output logic [2**REG_AW-1:0] pending_o
);
  localparam int PW = $clog2(DEPTH);
  fpu_wb_entry_t mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q;
  logic          empty, pop;
  fpu_wb_entry_t head;
  assign head        = mem_q[rd_q];
  assign empty       = cnt_q == '0;
  assign full_o      = cnt_q == (PW+1)'(DEPTH);
  // killed heads are discarded even while the pipeline owns the port
  assign pop         = !empty && (!head.valid || !pfw_i);
  assign drain_o     = !empty && head.valid && !pfw_i;
  assign head_rd_o   = head.rd;
  assign head_data_o = head.data;
  always_comb begin
    pending_o = '0;
    for (int i = 0; i < DEPTH; i++)
      if (mem_q[i].valid) pending_o[mem_q[i].rd] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (pfw_i && mem_q[i].rd == pfw_rd_i) mem_q[i].valid <= 1'b0;
      if (pop) begin
        mem_q[rd_q].valid <= 1'b0;
        rd_q <= rd_q + PW'(1);
      end
      // written last so a same-cycle matching pipeline write cannot kill it
      if (enq_i) begin
        mem_q[wr_q] <= '{valid: 1'b1, rd: enq_rd_i, data: enq_data_i};
        wr_q <= wr_q + PW'(1);
      end
      cnt_q <= cnt_q + (PW+1)'(enq_i) - (PW+1)'(pop);
    end
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: writeback mux and integer/FP write-port arbitration with late FPU merge.
// Define WB_FPU_BYPASS_EN to let an FPU result write the FP port directly when the buffer is idle.
module wb_stage
  import wb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REG_AW-1:0]    mem_wb_register_rd,
  input  logic [XLEN-1:0]      result_mem_wb,
  input  logic [XLEN-1:0]      read_data_mem_wb,
  input  logic                 mem_wb_memtoreg,
  input  logic                 mem_wb_regwrite,
  input  logic                 mem_wb_regwrite_control_float,
  input  logic                 mem_wb_rd_sel,
  input  logic                 fpu_wb_valid,
  output logic                 fpu_wb_ready,
  input  logic [REG_AW-1:0]    fpu_wb_rd,
  input  logic [XLEN-1:0]      fpu_wb_data,
  output logic                 int_we,
  output logic [REG_AW-1:0]    int_waddr,
  output logic [XLEN-1:0]      int_wdata,
  output logic                 fp_we,
  output logic [REG_AW-1:0]    fp_waddr,
  output logic [XLEN-1:0]      fp_wdata,
  output logic [2**REG_AW-1:0] fp_pending
);
  logic              pfw, accept, bypass, enq, drain, full;
  logic [XLEN-1:0]   wb_data, head_data;
  logic [REG_AW-1:0] head_rd;
  assign wb_data      = mem_wb_memtoreg ? read_data_mem_wb : result_mem_wb;
  assign pfw          = mem_wb_regwrite_control_float & mem_wb_rd_sel;
  assign int_we       = rst_n & mem_wb_regwrite & !mem_wb_rd_sel & |mem_wb_register_rd;
  assign int_waddr    = mem_wb_register_rd;
  assign int_wdata    = wb_data;
  assign fpu_wb_ready = rst_n & !full;
  assign accept       = fpu_wb_valid & fpu_wb_ready;
`ifdef WB_FPU_BYPASS_EN
  assign bypass       = accept & !(|fp_pending) & !pfw;
`else
  assign bypass       = 1'b0;
`endif
  assign enq          = accept & !bypass;
  assign fp_we        = rst_n & (pfw | drain | bypass);
  assign fp_waddr     = pfw ? mem_wb_register_rd : drain ? head_rd : fpu_wb_rd;
  assign fp_wdata     = pfw ? wb_data : drain ? head_data : fpu_wb_data;
  wb_fpu_buf u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .enq_i      (enq),
    .enq_rd_i   (fpu_wb_rd),
    .enq_data_i (fpu_wb_data),
    .pfw_i      (pfw & rst_n),
    .pfw_rd_i   (mem_wb_register_rd),
    .full_o     (full),
    .drain_o    (drain),
    .head_rd_o  (head_rd),
    .head_data_o(head_data),
    .pending_o  (fp_pending)
  );
endmodule
